tx_axis_rr_arbiter: RTL and testbench
=====================================

// Module: tx_axis_rr_arbiter
// PURPOSE
// - Packet-level round-robin arbiter sharing the 10G MAC TX AXI-stream (64b) among NUM_REQ RX FIFO bridges.
// - Grants whole frames only (never interleaves beats); combinational data path, registered grant/state.
// - Includes a max-length watchdog: over-long frames are truncated on the MAC side, remainder drained from the source.
// PARAMETERS
// NUM_REQ    4     number of requesting streams (2..8)
// MAX_WORDS  1200  max 64b beats per frame before truncation (>=2)
// PORTS
// Clk156M25        in   1           MAC clock, all logic on rising edge
// RstMac           in   1           async reset, active-high
// s_axis_tdata     in   64*NUM_REQ  requester data, req i at [64*i+:64]
// s_axis_tkeep     in   8*NUM_REQ   requester byte enables, req i at [8*i+:8]
// s_axis_tvalid    in   NUM_REQ     requester valid
// s_axis_tlast     in   NUM_REQ     requester end-of-frame
// s_axis_tready    out  NUM_REQ     requester ready
// m_axis_tdata     out  64          to MAC
// m_axis_tkeep     out  8           to MAC
// m_axis_tvalid    out  1           to MAC
// m_axis_tlast     out  1           to MAC
// m_axis_tready    in   1           from MAC
// GrantVec         out  NUM_REQ     one-hot current owner (0 in IDLE)
// TruncErr_Cnt     out  32          frames truncated by watchdog, saturating
// BEHAVIOUR
// - Reset: state IDLE, GrantVec=0, RR pointer=0 (req 0 highest), word count=0, TruncErr_Cnt=0; all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep=0.
// - IDLE: if any s_axis_tvalid, pick first valid req scanning from pointer upward (mod NUM_REQ); next cycle GrantVec=one-hot, state SEND. No beat transfers in the arbitration cycle (1-cycle grant latency).
// - SEND: m_axis_{tdata,tkeep,tvalid,tlast}=granted req's signals; s_axis_tready[g]=m_axis_tready, others 0. Beat = tvalid&tready.
// - Word count increments per beat; reset to 0 on leaving SEND/DROP.
// - SEND exit: beat with tlast -> IDLE, pointer=g+1 (wrap NUM_REQ-1 -> 0), GrantVec=0. Back-to-back frames: min 1 idle cycle between grants.
// - Watchdog: beat number MAX_WORDS (count==MAX_WORDS-1) without source tlast -> m_axis_tlast forced 1, m_axis_tkeep forced 8'hff, TruncErr_Cnt+1 (saturate at FFFF_FFFF), state DROP.
// - Source tlast exactly on beat MAX_WORDS: normal end, no truncation.
// - DROP: m_axis_tvalid=0; s_axis_tready[g]=1; discard beats until source tlast beat -> IDLE, pointer=g+1.
// - m_axis_tready low: hold; source stalled via tready; no state change. Granted source dropping tvalid mid-frame: wait (no timeout).
// - Non-granted requesters see tready=0 always; their inputs ignored.
// - Reset mid-frame: immediate return to IDLE, outputs to reset values; partial frame on MAC not completed (MAC discards).
// CONFIGURATION
// - ARB_STATS_EN defined: adds ports CntClr (in,1, async clear, active-high, clears counters) and GrantPkt_Cnt (out, 32*NUM_REQ, req i at [32*i+:32]): per-req count of frames completed on MAC side (incl. truncated), wraps at 2^32.
// - ARB_STATS_EN undefined: those ports and counters absent; TruncErr_Cnt present either way, cleared only by RstMac.
// TESTING
// - Reset, all idle -> s_axis_tready=0, m_axis_tvalid=0, GrantVec=0, TruncErr_Cnt=0.
// - Reqs 0..3 each one 4-beat frame valid simultaneously, m_axis_tready=1 -> MAC sees frames in order 0,1,2,3, each tlast on beat 4, 1 idle cycle between.
// - Req 1 and 2 both valid continuously, 2 frames each -> order 1,2,1,2 after initial grant of 1; no beat interleaving.
// - MAC tready toggles 1010 during 8-beat frame from req 0 -> 8 beats delivered intact, tkeep last = source tkeep (e.g. 8'h0f).
// - MAX_WORDS=4, req 2 sends 6-beat frame -> MAC gets 4 beats, tlast on 4th, tkeep 8'hff; beats 5-6 drained; TruncErr_Cnt=1; next grant starts at req 3.
// - RstMac pulse on beat 3 of 5-beat frame -> outputs zero next edge; after release, pending req 0 granted fresh (ARB_STATS_EN: GrantPkt_Cnt unchanged by aborted frame).

Source files
------------

// File: rtl/tx_axis_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one 64b MAC TX AXI-stream among NUM_REQ sources.
// Define ARB_STATS_EN to add per-requester frame counters and the CntClr clear input.
module tx_axis_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_WORDS = 1200
) (
    input  logic                  Clk156M25,
    input  logic                  RstMac,
    input  logic [64*NUM_REQ-1:0] s_axis_tdata,
    input  logic [8*NUM_REQ-1:0]  s_axis_tkeep,
    input  logic [NUM_REQ-1:0]    s_axis_tvalid,
    input  logic [NUM_REQ-1:0]    s_axis_tlast,
    output logic [NUM_REQ-1:0]    s_axis_tready,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [NUM_REQ-1:0]    GrantVec,
`ifdef ARB_STATS_EN
    input  logic                  CntClr,
    output logic [32*NUM_REQ-1:0] GrantPkt_Cnt,
`endif
    output logic [31:0]           TruncErr_Cnt
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]         r_state;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [CW-1:0]      r_wcnt;
    logic [31:0]        r_trunc_cnt;

    logic               w_any;
    logic [IW-1:0]      w_pick;
    logic [IW:0]        w_scan;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [63:0]        w_src_data;
    logic [7:0]         w_src_keep;
    logic               w_src_valid;
    logic               w_src_last;
    logic [IW-1:0]      w_ptr_next;
    logic               w_at_limit;
    logic               w_send_beat;
    logic               w_trunc_beat;

    // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_scan = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_scan >= (IW+1)'(NUM_REQ))
                w_scan = w_scan - (IW+1)'(NUM_REQ);
            if (!w_any && s_axis_tvalid[w_scan[IW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_scan[IW-1:0];
            end
        end
    end

    always_comb begin
        w_src_data  = '0;
        w_src_keep  = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_gidx == IW'(i)) begin
                w_src_data  = s_axis_tdata[64*i +: 64];
                w_src_keep  = s_axis_tkeep[8*i +: 8];
                w_src_valid = s_axis_tvalid[i];
                w_src_last  = s_axis_tlast[i];
            end
        end
    end

    assign w_pick_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_ptr_next   = (r_gidx == IW'(NUM_REQ-1)) ? '0 : r_gidx + 1'b1;
    assign w_at_limit   = (r_wcnt == CW'(MAX_WORDS-1));
    assign w_send_beat  = (r_state == ST_SEND) && w_src_valid && m_axis_tready;
    assign w_trunc_beat = w_send_beat && w_at_limit && !w_src_last;

    // The MAC only ever sees the owner in SEND; the last permitted beat is forced to end the frame.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_SEND: begin
                m_axis_tdata  = w_src_data;
                m_axis_tkeep  = (w_at_limit && !w_src_last) ? 8'hff : w_src_keep;
                m_axis_tvalid = w_src_valid;
                m_axis_tlast  = w_src_last || w_at_limit;
                s_axis_tready = r_grant & {NUM_REQ{m_axis_tready}};
            end
            ST_DROP: s_axis_tready = r_grant;
            default: ;
        endcase
    end

    always_ff @(posedge Clk156M25 or posedge RstMac) begin
        if (RstMac) begin
            r_state <= ST_IDLE;
            r_gidx  <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_SEND;
                        r_gidx  <= w_pick;
                        r_grant <= w_pick_oh;
                    end
                end
                ST_SEND: begin
                    if (w_send_beat) begin
                        if (w_src_last) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_ptr_next;
                            r_grant <= '0;
                            r_wcnt  <= '0;
                        end else if (w_at_limit) begin
                            r_state <= ST_DROP;
                            r_wcnt  <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_src_valid && w_src_last) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_ptr_next;
                        r_grant <= '0;
                        r_wcnt  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [32*NUM_REQ-1:0] r_pkt_cnt;
    logic                  w_frame_done;

    assign w_frame_done = w_send_beat && (w_src_last || w_at_limit);

    always_ff @(posedge Clk156M25 or posedge RstMac or posedge CntClr) begin
        if (RstMac || CntClr) begin
            r_pkt_cnt <= '0;
        end else if (w_frame_done) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (r_grant[i])
                    r_pkt_cnt[32*i +: 32] <= r_pkt_cnt[32*i +: 32] + 32'd1;
            end
        end
    end

    assign GrantPkt_Cnt = r_pkt_cnt;

    always_ff @(posedge Clk156M25 or posedge RstMac or posedge CntClr) begin
        if (RstMac || CntClr)
            r_trunc_cnt <= '0;
`else
    always_ff @(posedge Clk156M25 or posedge RstMac) begin
        if (RstMac)
            r_trunc_cnt <= '0;
`endif
        else if (w_trunc_beat && (r_trunc_cnt != '1))
            r_trunc_cnt <= r_trunc_cnt + 32'd1;
    end

    assign GrantVec     = r_grant;
    assign TruncErr_Cnt = r_trunc_cnt;

endmodule

// File: tb/tb_tx_axis_rr_arbiter.sv
// Bench for tx_axis_rr_arbiter: vector table, directed frame sequences and randomized
// traffic checked against a cycle-level behavioural model and a frame scoreboard.
module tb_tx_axis_rr_arbiter;
    localparam int NREQ = 4;
    localparam int MAXW = 8;

    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
    typedef struct { int req; int beats; logic [7:0] lastkeep; int fid; int first_cyc; int last_cyc; } frame_t;
    typedef struct { int req; int len; logic [7:0] lastkeep; int fid; } gen_t;
    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] last;
        logic            mready;
        logic [NREQ-1:0] e_grant;
        logic            e_mvalid;
        logic            e_mlast;
        logic [NREQ-1:0] e_sready;
        int              e_owner;
    } vec_t;

    logic                Clk156M25 = 1'b0;
    logic                RstMac    = 1'b1;
    logic [64*NREQ-1:0]  s_axis_tdata  = '0;
    logic [8*NREQ-1:0]   s_axis_tkeep  = '0;
    logic [NREQ-1:0]     s_axis_tvalid = '0;
    logic [NREQ-1:0]     s_axis_tlast  = '0;
    logic [NREQ-1:0]     s_axis_tready;
    logic [63:0]         m_axis_tdata;
    logic [7:0]          m_axis_tkeep;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tready = 1'b0;
    logic [NREQ-1:0]     GrantVec;
    logic [31:0]         TruncErr_Cnt;

    tx_axis_rr_arbiter #(.NUM_REQ(NREQ), .MAX_WORDS(MAXW)) u_dut (
        .Clk156M25     (Clk156M25),
        .RstMac        (RstMac),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .GrantVec      (GrantVec),
        .TruncErr_Cnt  (TruncErr_Cnt)
    );

    always #5 Clk156M25 = ~Clk156M25;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     next_fid = 0;
    beat_t  srcq[NREQ][$];
    gen_t   gen_q[NREQ][$];
    bit     held[NREQ];
    frame_t mac_frames[$];
    int     mon_n = 0;
    int     mon_first = 0;
    bit     rnd_gaps = 1'b0;

    // Behavioural model state: owner -1 means no frame in progress.
    int          m_owner = -1;
    int          m_ptr = 0;
    int          m_cnt = 0;
    bit          m_drop = 1'b0;
    int unsigned m_trunc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < NREQ; i++)
            if (srcq[i].size() > 0) return 1'b1;
        return m_owner >= 0;
    endfunction

    task automatic add_frame(input int req, input int len, input logic [7:0] lastkeep);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.data = {8'(req), 24'(next_fid), 32'(b)};
            bt.keep = (b == len - 1) ? lastkeep : 8'hff;
            bt.last = (b == len - 1);
            srcq[req].push_back(bt);
        end
        gen_q[req].push_back('{req, len, lastkeep, next_fid});
        next_fid++;
    endtask

    task automatic clear_tb();
        for (int i = 0; i < NREQ; i++) begin
            srcq[i].delete();
            gen_q[i].delete();
            held[i] = 1'b0;
        end
        mac_frames.delete();
        mon_n = 0;
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_drop = 1'b0; m_trunc = 0;
        s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; s_axis_tkeep = '0;
    endtask

    task automatic do_reset();
        RstMac = 1'b1;
        clear_tb();
        repeat (2) @(posedge Clk156M25);
        @(negedge Clk156M25);
        RstMac = 1'b0;
        @(posedge Clk156M25);
        #1;
    endtask

    task automatic drive(input int mode);
        s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; s_axis_tkeep = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (srcq[i].size() > 0 && (held[i] || !rnd_gaps || $urandom_range(0, 3) != 0)) begin
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[64*i +: 64] = srcq[i][0].data;
                s_axis_tkeep[8*i +: 8]   = srcq[i][0].keep;
                s_axis_tlast[i]          = srcq[i][0].last;
            end
        end
        case (mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cyc % 2 == 0);
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // Expected outputs this cycle from the arbitration rules, then advance the model.
    task automatic model_eval(output logic [NREQ-1:0] acc);
        logic [NREQ-1:0] e_grant, e_sready;
        logic            e_valid, e_last;
        logic [63:0]     e_data;
        logic [7:0]      e_keep;
        int              o, nxt, j;
        bit              lim;
        e_grant = '0; e_sready = '0; e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_keep = '0;
        o = m_owner; nxt = -1; lim = 1'b0;
        if (o < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (nxt < 0 && s_axis_tvalid[j]) nxt = j;
            end
        end else begin
            e_grant[o] = 1'b1;
            if (!m_drop) begin
                lim         = (m_cnt == MAXW - 1);
                e_valid     = s_axis_tvalid[o];
                e_data      = s_axis_tdata[64*o +: 64];
                e_last      = s_axis_tlast[o] || lim;
                e_keep      = (lim && !s_axis_tlast[o]) ? 8'hff : s_axis_tkeep[8*o +: 8];
                e_sready[o] = m_axis_tready;
            end else begin
                e_sready[o] = 1'b1;
            end
        end
        chk("GrantVec", GrantVec, e_grant);
        chk("m_tvalid", m_axis_tvalid, e_valid);
        chk("s_tready", s_axis_tready, e_sready);
        chk("TruncErr_Cnt", TruncErr_Cnt, m_trunc);
        if (e_valid) begin
            chk("m_tdata", m_axis_tdata, e_data);
            chk("m_tkeep", m_axis_tkeep, e_keep);
            chk("m_tlast", m_axis_tlast, e_last);
        end
        acc = e_sready & s_axis_tvalid;
        if (o < 0) begin
            m_owner = nxt;
        end else if ((!m_drop && s_axis_tvalid[o] && m_axis_tready) || (m_drop && s_axis_tvalid[o])) begin
            if (s_axis_tlast[o]) begin
                m_owner = -1; m_ptr = (o + 1) % NREQ; m_cnt = 0; m_drop = 1'b0;
            end else if (!m_drop && lim) begin
                m_drop = 1'b1; m_cnt = 0;
                if (m_trunc != 32'hffff_ffff) m_trunc++;
            end else if (!m_drop) begin
                m_cnt++;
            end
        end
    endtask

    task automatic monitor();
        if (m_axis_tvalid && m_axis_tready) begin
            if (mon_n == 0) mon_first = cyc;
            mon_n++;
            if (m_axis_tlast) begin
                frame_t f;
                f.req = int'(m_axis_tdata[63:56]); f.fid = int'(m_axis_tdata[55:32]);
                f.beats = mon_n; f.lastkeep = m_axis_tkeep; f.first_cyc = mon_first; f.last_cyc = cyc;
                mac_frames.push_back(f);
                mon_n = 0;
            end
        end
    endtask

    task automatic cycle(input int mode);
        logic [NREQ-1:0] acc;
        drive(mode);
        @(negedge Clk156M25);
        model_eval(acc);
        monitor();
        @(posedge Clk156M25);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            held[i] = s_axis_tvalid[i] && !acc[i];
            if (acc[i]) void'(srcq[i].pop_front());
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int mode, input int maxc, input string name);
        int n = 0;
        while (busy() && n < maxc) begin
            cycle(mode);
            n++;
        end
        chk({"timeout ", name}, busy(), 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tv[14];
        frame_t f;
        gen_t g;
        int n, exp_trunc, fid_fresh, len, r;

        // Reset state
        do_reset();
        @(negedge Clk156M25);
        chk("rst s_tready", s_axis_tready, '0);
        chk("rst m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst m_tlast", m_axis_tlast, 1'b0);
        chk("rst m_tdata", m_axis_tdata, '0);
        chk("rst m_tkeep", m_axis_tkeep, '0);
        chk("rst GrantVec", GrantVec, '0);
        chk("rst TruncErr", TruncErr_Cnt, '0);
        @(posedge Clk156M25);
        #1;

        // Table: reqs 1 and 2 continuously valid, 2-beat frames, one MAC stall.
        tv[0]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, -1};
        tv[1]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010,  1};
        tv[2]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010,  1};
        tv[3]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, -1};
        tv[4]  = '{4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100,  2};
        tv[5]  = '{4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100,  2};
        tv[6]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, -1};
        tv[7]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000,  1};
        tv[8]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010,  1};
        tv[9]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010,  1};
        tv[10] = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, -1};
        tv[11] = '{4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100,  2};
        tv[12] = '{4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100,  2};
        tv[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, -1};
        for (int i = 0; i < NREQ; i++) begin
            s_axis_tdata[64*i +: 64] = {32'hC0DE_0000 + 32'(i), 32'h0};
            s_axis_tkeep[8*i +: 8]   = 8'hff;
        end
        for (int k = 0; k < 14; k++) begin
            s_axis_tvalid = tv[k].valid;
            s_axis_tlast  = tv[k].last;
            m_axis_tready = tv[k].mready;
            @(negedge Clk156M25);
            chk($sformatf("tbl%0d GrantVec", k), GrantVec, tv[k].e_grant);
            chk($sformatf("tbl%0d m_tvalid", k), m_axis_tvalid, tv[k].e_mvalid);
            chk($sformatf("tbl%0d s_tready", k), s_axis_tready, tv[k].e_sready);
            if (tv[k].e_mvalid) begin
                chk($sformatf("tbl%0d m_tlast", k), m_axis_tlast, tv[k].e_mlast);
                chk($sformatf("tbl%0d m_tdata", k), m_axis_tdata, {32'hC0DE_0000 + 32'(tv[k].e_owner), 32'h0});
            end
            @(posedge Clk156M25);
            #1;
        end

        // Four simultaneous 4-beat frames: order 0..3, one idle cycle between frames.
        do_reset();
        rnd_gaps = 1'b0;
        for (int i = 0; i < NREQ; i++) add_frame(i, 4, 8'hff);
        run_until_idle(0, 100, "four_frames");
        chk("four frame count", mac_frames.size(), 4);
        for (int k = 0; k < mac_frames.size() && k < 4; k++) begin
            chk($sformatf("four order %0d", k), mac_frames[k].req, k);
            chk($sformatf("four beats %0d", k), mac_frames[k].beats, 4);
            if (k > 0)
                chk($sformatf("four gap %0d", k), mac_frames[k].first_cyc - mac_frames[k-1].last_cyc, 2);
        end

        // 8-beat frame from req 0 under toggling MAC tready; tlast exactly at MAXW.
        mac_frames.delete();
        add_frame(0, 8, 8'h0f);
        run_until_idle(1, 100, "toggle");
        chk("toggle frame count", mac_frames.size(), 1);
        if (mac_frames.size() > 0) begin
            chk("toggle beats", mac_frames[0].beats, 8);
            chk("toggle lastkeep", mac_frames[0].lastkeep, 8'h0f);
        end
        chk("toggle no trunc", TruncErr_Cnt, 0);

        // Over-long frame from req 2 truncated, remainder drained, pointer moves to req 3.
        mac_frames.delete();
        add_frame(2, 10, 8'h03);
        run_until_idle(0, 100, "trunc");
        chk("trunc frame count", mac_frames.size(), 1);
        if (mac_frames.size() > 0) begin
            chk("trunc req", mac_frames[0].req, 2);
            chk("trunc beats", mac_frames[0].beats, MAXW);
            chk("trunc lastkeep", mac_frames[0].lastkeep, 8'hff);
        end
        chk("trunc drained", srcq[2].size(), 0);
        chk("trunc counter", TruncErr_Cnt, 1);
        add_frame(1, 2, 8'hff);
        add_frame(3, 2, 8'hff);
        run_until_idle(0, 100, "after_trunc");
        chk("after trunc count", mac_frames.size(), 3);
        if (mac_frames.size() == 3) begin
            chk("after trunc first", mac_frames[1].req, 3);
            chk("after trunc second", mac_frames[2].req, 1);
        end

        // Reset asserted while beat 3 of a 5-beat frame is presented.
        do_reset();
        add_frame(0, 5, 8'hff);
        n = 0;
        while (!(m_owner == 0 && m_cnt == 2) && n < 20) begin
            cycle(0);
            n++;
        end
        chk("midrst reached beat3", (m_owner == 0 && m_cnt == 2), 1'b1);
        drive(0);
        #1 RstMac = 1'b1;
        #1;
        chk("midrst m_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst GrantVec", GrantVec, '0);
        chk("midrst s_tready", s_axis_tready, '0);
        chk("midrst m_tdata", m_axis_tdata, '0);
        @(posedge Clk156M25);
        #1;
        chk("midrst edge m_tlast", m_axis_tlast, 1'b0);
        chk("midrst edge GrantVec", GrantVec, '0);
        clear_tb();
        @(negedge Clk156M25);
        RstMac = 1'b0;
        @(posedge Clk156M25);
        #1;
        fid_fresh = next_fid;
        add_frame(0, 3, 8'h07);
        run_until_idle(0, 100, "midrst_fresh");
        chk("midrst frame count", mac_frames.size(), 1);
        if (mac_frames.size() > 0) begin
            chk("midrst fresh req", mac_frames[0].req, 0);
            chk("midrst fresh fid", mac_frames[0].fid, fid_fresh);
            chk("midrst fresh beats", mac_frames[0].beats, 3);
            chk("midrst fresh lastkeep", mac_frames[0].lastkeep, 8'h07);
        end

        // Randomized traffic with source gaps and MAC backpressure.
        do_reset();
        rnd_gaps = 1'b1;
        exp_trunc = 0;
        for (int k = 0; k < 60; k++) begin
            r   = $urandom_range(0, NREQ - 1);
            len = $urandom_range(1, MAXW + 3);
            add_frame(r, len, 8'($urandom_range(1, 255)));
            if (len > MAXW) exp_trunc++;
        end
        run_until_idle(2, 8000, "random");
        chk("rand frame count", mac_frames.size(), 60);
        foreach (mac_frames[k]) begin
            f = mac_frames[k];
            if (f.req < 0 || f.req >= NREQ || gen_q[f.req].size() == 0) begin
                chk($sformatf("rand frame %0d known source", k), 1'b0, 1'b1);
            end else begin
                g = gen_q[f.req].pop_front();
                chk($sformatf("rand frame %0d fid", k), f.fid, g.fid);
                chk($sformatf("rand frame %0d beats", k), f.beats, (g.len > MAXW) ? MAXW : g.len);
                chk($sformatf("rand frame %0d lastkeep", k), f.lastkeep, (g.len > MAXW) ? 8'hff : g.lastkeep);
            end
        end
        chk("rand trunc total", TruncErr_Cnt, exp_trunc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
